debounce_sync: RTL

//  Front-end conditioning stage for the push-button that drives the 8-bit event counter's enable.
//  - Synchronizes the asynchronous button into the clk domain.
//  - Rejects contact bounce with a stability-count FSM.
//  - Emits a one-cycle press pulse wired directly to the counter's enable.
//  - Also provides a debounced level and a release pulse for other consumers.

---
 rtl/debounce_pkg.sv | 11 +
 rtl/sync_ff.sv | 23 ++
 rtl/debounce_sync.sv | 107 ++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the push-button debounce front end.
package debounce_pkg;

  typedef enum logic [1:0] {IDLE, CHK_HI, HIGH, CHK_LO} db_state_t;

  // Width of a counter that must hold 0 .. n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic N-flop synchronizer with asynchronous active-low reset to 0.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Button conditioning: synchronizer, stability-count debounce FSM and registered
// level / press-pulse / release-pulse outputs.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_rel_pulse
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2) begin : g_param_check
    $error("debounce_sync: SYNC_STAGES and DEBOUNCE_CYCLES must both be >= 2");
  end

  logic btn_s;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (btn_in),
    .q_o   (btn_s)
  );

  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             rel_q, rel_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = CHK_HI;
          cnt_d   = '0;
        end
      end
      CHK_HI: begin
        // A revert on the terminal cycle takes priority over acceptance.
        if (!btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == CntMax) begin
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!btn_s) begin
          state_d = CHK_LO;
          cnt_d   = '0;
        end
      end
      CHK_LO: begin
        if (btn_s) begin
          state_d = HIGH;
        end else if (cnt_q == CntMax) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pulses mark the edges of the registered level, so they coincide with its change.
  always_comb begin
    level_d = (state_q == HIGH) || (state_q == CHK_LO);
    pulse_d = level_d & ~level_q;
    rel_d   = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      rel_q   <= rel_d;
    end
  end

  assign btn_level     = level_q;
  assign btn_pulse     = pulse_q;
  assign btn_rel_pulse = rel_q;

endmodule
